// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC generation, in-order memory request tracking,
// a 2-entry decode buffer and redirect handling with stale-response discard.
module instruction_fetch_unit #(
   parameter int                       ADDRESS_WIDTH    = 32,
   parameter int                       DATA_WIDTH       = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = 32'h0000_0000,
   parameter int                       IMM_MAX_IN_WIDTH = 25
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        REDIRECT_VALID,
   input  logic [ADDRESS_WIDTH-1:0]    REDIRECT_PC,
   output logic                        IMEM_REQ_VALID,
   output logic [ADDRESS_WIDTH-1:0]    IMEM_REQ_ADDR,
   input  logic                        IMEM_REQ_READY,
   input  logic                        IMEM_RSP_VALID,
   input  logic [DATA_WIDTH-1:0]       IMEM_RSP_DATA,
   output logic                        ID_VALID,
   output logic [ADDRESS_WIDTH-1:0]    ID_PC,
   output logic [DATA_WIDTH-1:0]       ID_INSTR,
   output logic [IMM_MAX_IN_WIDTH-1:0] ID_IMM_INPUT,
   input  logic                        ID_READY
);

   logic                     running;
   logic [ADDRESS_WIDTH-1:0] pc_q;
   logic [ADDRESS_WIDTH-1:0] redirect_aligned;

   logic [ADDRESS_WIDTH-1:0] pcf_mem [2];
   logic                     pcf_wr;
   logic                     pcf_rd;

   logic [ADDRESS_WIDTH-1:0] buf_pc    [2];
   logic [DATA_WIDTH-1:0]    buf_instr [2];
   logic                     buf_wr;
   logic                     buf_rd;
   logic [1:0]               buf_cnt;

   logic [1:0]               out_cnt;
   logic [1:0]               discard_cnt;

   logic                     req_fire;
   logic                     rsp_counted;
   logic                     rsp_drop;
   logic                     rsp_keep;
   logic                     push;
   logic                     pop;
   logic [1:0]               out_nxt;
   logic [1:0]               discard_nxt;
   logic [1:0]               buf_cnt_nxt;

   // Handshake decode, output drive and counter next-state; redirect overrides everything
   always_comb begin
      redirect_aligned = REDIRECT_PC & ~ADDRESS_WIDTH'(3);
      IMEM_REQ_VALID   = running & ~REDIRECT_VALID &
                         (({1'b0, out_cnt} + {1'b0, buf_cnt}) < 3'd2);
      IMEM_REQ_ADDR    = pc_q;
      ID_VALID         = (buf_cnt != 2'd0);
      ID_PC            = buf_pc[buf_rd];
      ID_INSTR         = buf_instr[buf_rd];
      ID_IMM_INPUT     = ID_INSTR[IMM_MAX_IN_WIDTH+6:7];

      req_fire    = IMEM_REQ_VALID & IMEM_REQ_READY;
      // a response with nothing outstanding is a protocol error and is ignored
      rsp_counted = IMEM_RSP_VALID & (out_cnt != 2'd0);
      rsp_drop    = rsp_counted & (discard_cnt != 2'd0);
      rsp_keep    = rsp_counted & (discard_cnt == 2'd0) & ~REDIRECT_VALID;
      pop         = ID_VALID & ID_READY & ~REDIRECT_VALID;
      push        = rsp_keep & (pop | (buf_cnt != 2'd2));

      out_nxt = out_cnt;
      if (req_fire && !rsp_counted && out_cnt != 2'd2)
         out_nxt = out_cnt + 2'd1;
      else if (!req_fire && rsp_counted)
         out_nxt = out_cnt - 2'd1;

      // every request still in flight at a redirect becomes stale
      discard_nxt = discard_cnt;
      if (REDIRECT_VALID)
         discard_nxt = out_cnt - {1'b0, rsp_counted};
      else if (rsp_drop)
         discard_nxt = discard_cnt - 2'd1;

      buf_cnt_nxt = buf_cnt;
      if (REDIRECT_VALID)
         buf_cnt_nxt = 2'd0;
      else if (push && !pop)
         buf_cnt_nxt = buf_cnt + 2'd1;
      else if (pop && !push)
         buf_cnt_nxt = buf_cnt - 2'd1;
   end

   // Hold off fetching until the first edge after reset release
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         running <= 1'b0;
      else
         running <= 1'b1;
   end

   // Program counter: redirect target wins over sequential advance
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         pc_q <= RESET_PC;
      else if (REDIRECT_VALID)
         pc_q <= redirect_aligned;
      else if (req_fire)
         pc_q <= pc_q + ADDRESS_WIDTH'(4);
   end

   // PC FIFO pairing each kept response with its oldest non-stale request address
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pcf_wr <= 1'b0;
         pcf_rd <= 1'b0;
         for (int unsigned i = 0; i < 2; i++)
            pcf_mem[i] <= '0;
      end else if (REDIRECT_VALID) begin
         pcf_wr <= 1'b0;
         pcf_rd <= 1'b0;
      end else begin
         if (req_fire) begin
            pcf_mem[pcf_wr] <= pc_q;
            pcf_wr          <= ~pcf_wr;
         end
         if (rsp_keep)
            pcf_rd <= ~pcf_rd;
      end
   end

   // Outstanding and discard counters
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_cnt     <= '0;
         discard_cnt <= '0;
      end else begin
         out_cnt     <= out_nxt;
         discard_cnt <= discard_nxt;
      end
   end

   // Decode buffer: in-order {PC, instruction} pairs, head presented on ID_*
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         buf_wr  <= 1'b0;
         buf_rd  <= 1'b0;
         buf_cnt <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            buf_pc[i]    <= '0;
            buf_instr[i] <= '0;
         end
      end else begin
         buf_cnt <= buf_cnt_nxt;
         if (REDIRECT_VALID) begin
            buf_wr <= 1'b0;
            buf_rd <= 1'b0;
         end else begin
            if (push) begin
               buf_pc[buf_wr]    <= pcf_mem[pcf_rd];
               buf_instr[buf_wr] <= IMEM_RSP_DATA;
               buf_wr            <= ~buf_wr;
            end
            if (pop)
               buf_rd <= ~buf_rd;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a latency-configurable
// in-order memory model feeds a scoreboard of expected decode entries.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        CLK;
   logic        RST_N;
   logic        REDIRECT_VALID;
   logic [31:0] REDIRECT_PC;
   logic        IMEM_REQ_VALID;
   logic [31:0] IMEM_REQ_ADDR;
   logic        IMEM_REQ_READY;
   logic        IMEM_RSP_VALID;
   logic [31:0] IMEM_RSP_DATA;
   logic        ID_VALID;
   logic [31:0] ID_PC;
   logic [31:0] ID_INSTR;
   logic [24:0] ID_IMM_INPUT;
   logic        ID_READY;

   instruction_fetch_unit #(
      .ADDRESS_WIDTH    (32),
      .DATA_WIDTH       (32),
      .RESET_PC         (RESET_PC),
      .IMM_MAX_IN_WIDTH (25)
   ) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .REDIRECT_VALID (REDIRECT_VALID),
      .REDIRECT_PC    (REDIRECT_PC),
      .IMEM_REQ_VALID (IMEM_REQ_VALID),
      .IMEM_REQ_ADDR  (IMEM_REQ_ADDR),
      .IMEM_REQ_READY (IMEM_REQ_READY),
      .IMEM_RSP_VALID (IMEM_RSP_VALID),
      .IMEM_RSP_DATA  (IMEM_RSP_DATA),
      .ID_VALID       (ID_VALID),
      .ID_PC          (ID_PC),
      .ID_INSTR       (ID_INSTR),
      .ID_IMM_INPUT   (ID_IMM_INPUT),
      .ID_READY       (ID_READY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [31:0] model_addr;
      logic [31:0] dut_addr;
      int          cnt;
      bit          stale;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   pend_t       pend[$];
   ent_t        sb[$];
   logic [31:0] xfer_pcs[$];
   logic [24:0] last_imm;
   logic [31:0] exp_pc;
   bit          running;
   bit          inject_rsp;
   int          lat_min;
   int          lat_max;
   int          vectors;
   int          miscompares;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h0000_0200)
         return 32'hFFF0_0093;
      return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
   endfunction

   // One clock cycle; entered at a falling edge with the caller's inputs set
   task automatic cycle();
      pend_t head;
      pend_t np;
      ent_t  e;
      bit    rsp;
      bit    exp_v;
      bit    acc;
      int    out_n;
      int    stale_n;
      out_n   = pend.size();
      stale_n = 0;
      foreach (pend[i]) if (pend[i].stale) stale_n++;
      rsp = 0;
      if (pend.size() > 0 && pend[0].cnt == 0) begin
         head           = pend.pop_front();
         rsp            = 1;
         IMEM_RSP_VALID = 1'b1;
         IMEM_RSP_DATA  = mem_data(head.dut_addr);
      end else if (inject_rsp) begin
         IMEM_RSP_VALID = 1'b1;
         IMEM_RSP_DATA  = 32'hDEAD_BEEF;
      end else begin
         IMEM_RSP_VALID = 1'b0;
         IMEM_RSP_DATA  = '0;
      end
      #1;
      exp_v = running && !REDIRECT_VALID && (out_n + sb.size() < 2);
      vectors++;
      if (IMEM_REQ_VALID !== exp_v) begin
         miscompares++;
         $display("FAIL req_valid @%0t: got %b expected %b", $time, IMEM_REQ_VALID, exp_v);
      end
      if (exp_v) begin
         vectors++;
         if (IMEM_REQ_ADDR !== exp_pc) begin
            miscompares++;
            $display("FAIL req_addr @%0t: got %h expected %h", $time, IMEM_REQ_ADDR, exp_pc);
         end
      end
      vectors++;
      if (ID_VALID !== (sb.size() > 0)) begin
         miscompares++;
         $display("FAIL id_valid @%0t: got %b expected %b", $time, ID_VALID, sb.size() > 0);
      end
      vectors++;
      if (int'(dut.discard_cnt) != stale_n) begin
         miscompares++;
         $display("FAIL discard @%0t: got %0d expected %0d", $time, dut.discard_cnt, stale_n);
      end
      if (sb.size() > 0) begin
         vectors++;
         if (ID_PC !== sb[0].pc || ID_INSTR !== sb[0].instr || ID_IMM_INPUT !== sb[0].instr[31:7]) begin
            miscompares++;
            $display("FAIL id_entry @%0t: got pc %h instr %h imm %h expected pc %h instr %h imm %h",
                     $time, ID_PC, ID_INSTR, ID_IMM_INPUT, sb[0].pc, sb[0].instr, sb[0].instr[31:7]);
         end
      end
      if (!REDIRECT_VALID && ID_READY && sb.size() > 0) begin
         e        = sb.pop_front();
         last_imm = ID_IMM_INPUT;
         xfer_pcs.push_back(e.pc);
      end
      foreach (pend[i]) if (pend[i].cnt > 0) pend[i].cnt--;
      acc = IMEM_REQ_VALID && IMEM_REQ_READY;
      if (acc) begin
         np.model_addr = exp_pc;
         np.dut_addr   = IMEM_REQ_ADDR;
         np.cnt        = $urandom_range(lat_max, lat_min) - 1;
         np.stale      = 0;
         pend.push_back(np);
         exp_pc = exp_pc + 32'd4;
      end
      if (REDIRECT_VALID) begin
         sb.delete();
         foreach (pend[i]) pend[i].stale = 1;
         exp_pc = {REDIRECT_PC[31:2], 2'b00};
      end else if (rsp && !head.stale) begin
         e.pc    = head.model_addr;
         e.instr = mem_data(head.model_addr);
         sb.push_back(e);
      end
      if (RST_N) running = 1;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST_N          = 1'b0;
      REDIRECT_VALID = 1'b0;
      REDIRECT_PC    = '0;
      IMEM_REQ_READY = 1'b0;
      IMEM_RSP_VALID = 1'b0;
      IMEM_RSP_DATA  = '0;
      ID_READY       = 1'b0;
      inject_rsp     = 0;
      pend.delete();
      sb.delete();
      exp_pc  = RESET_PC;
      running = 0;
      #1;
      vectors++;
      if (IMEM_REQ_VALID !== 1'b0 || ID_VALID !== 1'b0 || ID_PC !== '0 ||
          ID_INSTR !== '0 || ID_IMM_INPUT !== '0 || dut.discard_cnt !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_state @%0t: got req_valid %b id_valid %b pc %h instr %h imm %h discard %0d expected all zero",
                  $time, IMEM_REQ_VALID, ID_VALID, ID_PC, ID_INSTR, ID_IMM_INPUT, dut.discard_cnt);
      end
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      lat_min = 1;
      lat_max = 1;
      cycle();
   endtask

   task automatic test_stream();
      do_reset();
      lat_min = 1; lat_max = 1;
      ID_READY = 1'b1; IMEM_REQ_READY = 1'b1;
      xfer_pcs.delete();
      repeat (14) cycle();
      vectors++;
      if (xfer_pcs.size() < 3) begin
         miscompares++;
         $display("FAIL stream_count: got %0d transfers expected at least 3", xfer_pcs.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (xfer_pcs[k] !== 32'(4 * k)) begin
               miscompares++;
               $display("FAIL stream_pc[%0d]: got %h expected %h", k, xfer_pcs[k], 32'(4 * k));
            end
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      lat_min = 1; lat_max = 1;
      ID_READY = 1'b0; IMEM_REQ_READY = 1'b1;
      repeat (5) cycle();
      #1;
      vectors++;
      if (dut.buf_cnt !== 2'd2 || IMEM_REQ_VALID !== 1'b0 || ID_PC !== 32'h0) begin
         miscompares++;
         $display("FAIL stall_full: got count %0d req_valid %b id_pc %h expected 2 0 00000000",
                  dut.buf_cnt, IMEM_REQ_VALID, ID_PC);
      end
      ID_READY = 1'b1;
      xfer_pcs.delete();
      repeat (6) cycle();
      vectors++;
      if (xfer_pcs.size() < 2 || xfer_pcs[0] !== 32'h0 || xfer_pcs[1] !== 32'h4) begin
         miscompares++;
         $display("FAIL stall_drain: got %0d transfers first %h expected 00000000 then 00000004",
                  xfer_pcs.size(), (xfer_pcs.size() > 0) ? xfer_pcs[0] : 32'hX);
      end
   endtask

   task automatic test_redirect();
      int n;
      do_reset();
      lat_min = 3; lat_max = 3;
      ID_READY = 1'b1; IMEM_REQ_READY = 1'b1;
      n = 0;
      while (pend.size() < 2 && n < 20) begin
         cycle();
         n++;
      end
      vectors++;
      if (pend.size() != 2) begin
         miscompares++;
         $display("FAIL redirect_setup: got %0d outstanding expected 2", pend.size());
      end
      REDIRECT_VALID = 1'b1;
      REDIRECT_PC    = 32'h0000_0103;
      cycle();
      REDIRECT_VALID = 1'b0;
      xfer_pcs.delete();
      n = 0;
      while (xfer_pcs.size() == 0 && n < 30) begin
         cycle();
         n++;
      end
      vectors++;
      if (xfer_pcs.size() == 0 || xfer_pcs[0] !== 32'h0000_0100) begin
         miscompares++;
         $display("FAIL redirect_first_pc: got %h expected 00000100",
                  (xfer_pcs.size() > 0) ? xfer_pcs[0] : 32'hX);
      end
   endtask

   task automatic test_rsp_pop_redirect();
      int n;
      int exp_disc;
      do_reset();
      lat_min = 1; lat_max = 1;
      ID_READY = 1'b1; IMEM_REQ_READY = 1'b1;
      n = 0;
      while (!(pend.size() > 0 && pend[0].cnt == 0 && sb.size() > 0) && n < 20) begin
         cycle();
         n++;
      end
      vectors++;
      if (n >= 20) begin
         miscompares++;
         $display("FAIL combo_setup: got no response+pop cycle expected one within 20 cycles");
      end
      exp_disc       = pend.size() - 1;
      REDIRECT_VALID = 1'b1;
      REDIRECT_PC    = 32'h0000_0040;
      cycle();
      REDIRECT_VALID = 1'b0;
      #1;
      vectors++;
      if (ID_VALID !== 1'b0 || int'(dut.discard_cnt) != exp_disc || IMEM_REQ_ADDR !== 32'h0000_0040) begin
         miscompares++;
         $display("FAIL combo_redirect: got id_valid %b discard %0d pc %h expected 0 %0d 00000040",
                  ID_VALID, dut.discard_cnt, IMEM_REQ_ADDR, exp_disc);
      end
      repeat (8) cycle();
   endtask

   task automatic test_imm();
      int n;
      do_reset();
      lat_min = 2; lat_max = 2;
      ID_READY = 1'b1; IMEM_REQ_READY = 1'b1;
      REDIRECT_VALID = 1'b1;
      REDIRECT_PC    = 32'h0000_0200;
      cycle();
      REDIRECT_VALID = 1'b0;
      xfer_pcs.delete();
      n = 0;
      while (xfer_pcs.size() == 0 && n < 20) begin
         cycle();
         n++;
      end
      vectors++;
      if (xfer_pcs.size() == 0 || xfer_pcs[0] !== 32'h0000_0200 || last_imm !== 25'h1FFE001) begin
         miscompares++;
         $display("FAIL imm_input: got pc %h imm %h expected pc 00000200 imm 1ffe001",
                  (xfer_pcs.size() > 0) ? xfer_pcs[0] : 32'hX, last_imm);
      end
   endtask

   task automatic test_protocol_error();
      logic [31:0] exp_first;
      IMEM_REQ_READY = 1'b0;
      ID_READY       = 1'b1;
      repeat (8) cycle();
      inject_rsp = 1;
      cycle();
      inject_rsp = 0;
      #1;
      vectors++;
      if (IMEM_REQ_VALID !== 1'b1 || ID_VALID !== 1'b0 || dut.out_cnt !== 2'd0) begin
         miscompares++;
         $display("FAIL stray_rsp: got req_valid %b id_valid %b outstanding %0d expected 1 0 0",
                  IMEM_REQ_VALID, ID_VALID, dut.out_cnt);
      end
      exp_first      = exp_pc;
      IMEM_REQ_READY = 1'b1;
      xfer_pcs.delete();
      repeat (10) cycle();
      vectors++;
      if (xfer_pcs.size() == 0 || xfer_pcs[0] !== exp_first) begin
         miscompares++;
         $display("FAIL stray_resume: got %h expected %h",
                  (xfer_pcs.size() > 0) ? xfer_pcs[0] : 32'hX, exp_first);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      lat_min = 1; lat_max = 4;
      repeat (400) begin
         IMEM_REQ_READY = ($urandom_range(3, 0) != 0);
         ID_READY       = ($urandom_range(9, 0) < 7);
         REDIRECT_VALID = ($urandom_range(29, 0) == 0);
         REDIRECT_PC    = $urandom & 32'h0000_0FFF;
         cycle();
      end
      REDIRECT_VALID = 1'b0;
   endtask

   task automatic test_reset_full();
      do_reset();
      lat_min = 1; lat_max = 1;
      ID_READY = 1'b0; IMEM_REQ_READY = 1'b1;
      repeat (6) cycle();
      vectors++;
      if (dut.buf_cnt !== 2'd2 || ID_VALID !== 1'b1) begin
         miscompares++;
         $display("FAIL prefill: got count %0d id_valid %b expected 2 1", dut.buf_cnt, ID_VALID);
      end
      #2;
      do_reset();
      ID_READY = 1'b1; IMEM_REQ_READY = 1'b1;
      repeat (8) cycle();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      lat_min     = 1;
      lat_max     = 1;
      inject_rsp  = 0;
      last_imm    = '0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_rsp_pop_redirect();
      test_imm();
      test_protocol_error();
      test_back_to_back();
      test_reset_full();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no completion expected finish before 2000000");
      $fatal(1, "timeout");
   end

endmodule
